// File: rtl/tech_pkg.sv
// Shared constants, width helper and state encoding for the one-hot encoder.
package tech_pkg;

    localparam int unsigned ENC_N = 4;

    // Index width for an n-bit one-hot word; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } enc_state_t;

endpackage

// File: rtl/encoder_4_2_if.sv
// Upstream/downstream handshake bundle for encoder_4_2.
interface encoder_4_2_if
    import tech_pkg::*;
#(
    parameter int unsigned N  = ENC_N,
    parameter int unsigned CW = 8
);
    localparam int unsigned W = idx_width(N);

    logic [N-1:0]  i_one_hot;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  o_binary;
    logic          o_error;
    logic          o_valid;
    logic          i_ready;
    logic          i_clear_count;
    logic [CW-1:0] o_err_count;

    modport master (
        output i_one_hot, i_valid, i_ready, i_clear_count,
        input  o_ready, o_binary, o_error, o_valid, o_err_count
    );

    modport slave (
        input  i_one_hot, i_valid, i_ready, i_clear_count,
        output o_ready, o_binary, o_error, o_valid, o_err_count
    );

endinterface

// File: rtl/onehot_enc_core.sv
// Combinational one-hot to index encoder with exactly-one-hot detection.
module onehot_enc_core
    import tech_pkg::*;
#(
    parameter int unsigned N = ENC_N,
    localparam int unsigned W  = idx_width(N),
    localparam int unsigned PW = $clog2(N + 1)
) (
    input  logic [N-1:0] i_one_hot,
    output logic [W-1:0] o_index,
    output logic         o_valid_onehot
);

    logic [PW-1:0] w_popcount;

    // Index is the OR of set-bit positions; only meaningful when exactly one bit is set.
    always_comb begin
        w_popcount = '0;
        o_index    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_popcount = w_popcount + PW'(i_one_hot[k]);
            if (i_one_hot[k]) begin
                o_index = o_index | W'(k);
            end
        end
        o_valid_onehot = (w_popcount == PW'(1));
    end

endmodule

// File: rtl/encoder_4_2.sv
// Registered one-hot to binary encoder with valid/ready handshake and a
// saturating count of malformed words.
module encoder_4_2
    import tech_pkg::*;
#(
    parameter int unsigned N  = ENC_N,
    parameter int unsigned CW = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    encoder_4_2_if.slave      enc
);

    localparam int unsigned W = idx_width(N);

    enc_state_t    r_state;
    logic [W-1:0]  r_binary;
    logic          r_error;
    logic [CW-1:0] r_err_count;

    logic [W-1:0]  w_index;
    logic          w_onehot_ok;
    logic          w_ready;
    logic          w_accept;
    logic          w_bad_accept;

    onehot_enc_core #(.N(N)) u_core (
        .i_one_hot      (enc.i_one_hot),
        .o_index        (w_index),
        .o_valid_onehot (w_onehot_ok)
    );

    assign w_ready      = (r_state == EMPTY) || enc.i_ready;
    assign w_accept     = enc.i_valid && w_ready;
    assign w_bad_accept = w_accept && !w_onehot_ok;

    // Output register and EMPTY/FULL control.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= EMPTY;
            r_binary <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_binary <= w_onehot_ok ? w_index : '0;
                r_error  <= !w_onehot_ok;
            end
            case (r_state)
                EMPTY: if (w_accept) r_state <= FULL;
                FULL:  if (enc.i_ready && !w_accept) r_state <= EMPTY;
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Clear wins over the old count but never swallows a same-cycle error.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err_count <= '0;
        end else if (enc.i_clear_count) begin
            r_err_count <= w_bad_accept ? CW'(1) : '0;
        end else if (w_bad_accept && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CW'(1);
        end
    end

    assign enc.o_ready     = w_ready;
    assign enc.o_valid     = (r_state == FULL);
    assign enc.o_binary    = r_binary;
    assign enc.o_error     = r_error;
    assign enc.o_err_count = r_err_count;

endmodule

// File: tb/tb_encoder_4_2.sv
// Directed bench for encoder_4_2: handshake, malformed codes, backpressure,
// counter saturation/clear and asynchronous reset.
module tb_encoder_4_2;
    import tech_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    encoder_4_2_if #(.N(4), .CW(8)) bus ();

    encoder_4_2 #(.N(4), .CW(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .enc     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] b, input logic e);
        check({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
        check({tag, ".binary"}, 32'(bus.o_binary), 32'(b));
        check({tag, ".error"}, 32'(bus.o_error), 32'(e));
    endtask

    initial begin
        rst               = 1'b1;
        bus.i_one_hot     = 4'b0000;
        bus.i_valid       = 1'b0;
        bus.i_ready       = 1'b1;
        bus.i_clear_count = 1'b0;

        tick();
        check_out("reset", 1'b0, 2'd0, 1'b0);
        check("reset.count", 32'(bus.o_err_count), 32'd0);
        check("reset.ready", 32'(bus.o_ready), 32'd1);
        rst = 1'b0;

        // Legal codes back-to-back
        bus.i_valid   = 1'b1;
        bus.i_one_hot = 4'b0001;
        tick(); check_out("legal0", 1'b1, 2'd0, 1'b0);
        bus.i_one_hot = 4'b0010;
        tick(); check_out("legal1", 1'b1, 2'd1, 1'b0);
        bus.i_one_hot = 4'b0100;
        tick(); check_out("legal2", 1'b1, 2'd2, 1'b0);
        bus.i_one_hot = 4'b1000;
        tick(); check_out("legal3", 1'b1, 2'd3, 1'b0);
        bus.i_valid   = 1'b0;
        tick(); check_out("drain", 1'b0, 2'd3, 1'b0);

        // Malformed words
        bus.i_valid   = 1'b1;
        bus.i_one_hot = 4'b0000;
        tick(); check_out("zerohot", 1'b1, 2'd0, 1'b1);
        check("zerohot.count", 32'(bus.o_err_count), 32'd1);
        bus.i_one_hot = 4'b0110;
        tick(); check_out("multihot", 1'b1, 2'd0, 1'b1);
        check("multihot.count", 32'(bus.o_err_count), 32'd2);
        bus.i_valid   = 1'b0;
        tick(); check("malformed.drain", 32'(bus.o_valid), 32'd0);

        // Backpressure
        bus.i_valid   = 1'b1;
        bus.i_one_hot = 4'b0100;
        tick(); check_out("bp.load", 1'b1, 2'd2, 1'b0);
        bus.i_ready   = 1'b0;
        bus.i_one_hot = 4'b1000;
        #1; check("bp.ready_low", 32'(bus.o_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("bp.hold", 1'b1, 2'd2, 1'b0);
            check("bp.hold.ready", 32'(bus.o_ready), 32'd0);
        end
        bus.i_ready = 1'b1;
        #1; check("bp.ready_high", 32'(bus.o_ready), 32'd1);
        tick(); check_out("bp.release", 1'b1, 2'd3, 1'b0);
        bus.i_valid = 1'b0;
        tick(); check("bp.drain", 32'(bus.o_valid), 32'd0);
        check("bp.count", 32'(bus.o_err_count), 32'd2);

        // Saturation: 260 malformed words on top of count 2
        bus.i_valid   = 1'b1;
        bus.i_one_hot = 4'b1111;
        for (int i = 0; i < 253; i++) tick();
        check("sat.reach", 32'(bus.o_err_count), 32'd255);
        for (int i = 0; i < 7; i++) tick();
        check("sat.hold", 32'(bus.o_err_count), 32'd255);
        check_out("sat.out", 1'b1, 2'd0, 1'b1);

        // Clear alone, then build count to 7, then clear collides with an error
        bus.i_valid       = 1'b0;
        bus.i_clear_count = 1'b1;
        tick(); check("clr.alone0", 32'(bus.o_err_count), 32'd0);
        bus.i_clear_count = 1'b0;
        bus.i_valid       = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("clr.seven", 32'(bus.o_err_count), 32'd7);
        bus.i_one_hot     = 4'b0011;
        bus.i_clear_count = 1'b1;
        tick(); check("clr.collide", 32'(bus.o_err_count), 32'd1);
        check_out("clr.collide", 1'b1, 2'd0, 1'b1);
        bus.i_valid = 1'b0;
        tick(); check("clr.alone1", 32'(bus.o_err_count), 32'd0);
        bus.i_clear_count = 1'b0;

        // Reset in the middle of a held result
        bus.i_valid   = 1'b1;
        bus.i_one_hot = 4'b0101;
        tick(); check("rst.pre.count", 32'(bus.o_err_count), 32'd1);
        bus.i_one_hot = 4'b1000;
        tick(); check_out("rst.pre", 1'b1, 2'd3, 1'b0);
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
        #1; rst = 1'b1;
        #1;
        check_out("rst.mid", 1'b0, 2'd0, 1'b0);
        check("rst.mid.count", 32'(bus.o_err_count), 32'd0);
        check("rst.mid.ready", 32'(bus.o_ready), 32'd1);
        #1; rst = 1'b0;
        bus.i_ready   = 1'b1;
        bus.i_valid   = 1'b1;
        bus.i_one_hot = 4'b0010;
        tick(); check_out("rst.after", 1'b1, 2'd1, 1'b0);
        bus.i_valid = 1'b0;
        tick(); check("rst.after.drain", 32'(bus.o_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_4_2.md
# encoder_4_2

Registered one-hot to binary encoder with a valid/ready handshake on both sides and invalid-code detection; it is the inverse of the existing 2-to-4 one-hot decoder. It takes one-hot select words from an upstream producer and hands a binary index plus an error flag to a downstream consumer one cycle later. A saturating counter records how many malformed (zero-hot or multi-hot) words were accepted.

## Interface
Parameters:
- N, 4, width of the one-hot input; legal range 2..16
- W, $clog2(N), width of the binary output; derived, not overridden
- CW, 8, width of the error counter

Ports:
- i_clk  input  1  sole clock; all state updates on the rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_one_hot  input  N  one-hot code word
- i_valid  input  1  i_one_hot is valid this cycle
- o_ready  output  1  block can accept a word this cycle
- o_binary  output  W  encoded index of the accepted word
- o_error  output  1  accepted word was not exactly one-hot
- o_valid  output  1  o_binary/o_error hold a result
- i_ready  input  1  downstream accepts the result this cycle
- i_clear_count  input  1  synchronous clear of o_err_count
- o_err_count  output  CW  saturating count of accepted malformed words

## Operation
- Single-entry output register. o_ready = !o_valid || i_ready (combinational, no dependency on i_valid).
- Accept: i_valid && o_ready at a rising edge. Register loads o_binary = index of the set bit, o_error = 0; o_valid = 1.
- Malformed word (popcount != 1): o_binary = 0, o_error = 1. Multi-hot does NOT resolve by priority.
- Drain: o_valid && i_ready with no accept -> o_valid = 0; o_binary/o_error keep last value.
- Simultaneous drain and accept: register replaced by the new word, o_valid stays 1 (full throughput, one word per cycle).
- Stall: o_valid && !i_ready -> o_binary, o_error, o_valid held unchanged; i_one_hot ignored while o_ready = 0.
- Error counter: +1 on each accepted malformed word; saturates at 2^CW-1 (255 default), never wraps.
- i_clear_count and an accepted malformed word in the same cycle -> counter = 1 (clear then count; no error lost). Clear alone -> 0.
- Two-state control: EMPTY (o_valid=0) and FULL (o_valid=1). EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on stall or drain+accept.

## Timing
- Latency: 1 cycle from accepting edge to o_valid/o_binary/o_error.
- Throughput: 1 word/cycle while i_ready = 1.
- Reset values (asynchronous, immediate on i_reset high): o_valid = 0, o_binary = 0, o_error = 0, o_err_count = 0; o_ready = 1 while in reset.
- Reset mid-operation: held result discarded, no partial transfer; first accept possible at the first rising edge after i_reset falls.
- o_ready combinational from o_valid and i_ready only; no path from i_valid or i_one_hot to o_ready.
- o_binary, o_error, o_valid, o_err_count are register outputs (no combinational path from inputs).

## Structure
- Shared package tech_pkg: constant ENC_N = 4, function clog2-based width helper, and state enum typedef enc_state_t {EMPTY, FULL}.
- One sub-module: onehot_enc_core, purely combinational, N-bit input -> W-bit index plus valid_onehot flag (popcount == 1). encoder_4_2 wraps it with the handshake register and error counter.

## Test plan
- Reset: assert i_reset mid-stream with o_valid=1 -> o_valid=0, o_binary=0, o_error=0, o_err_count=0 immediately, o_ready=1.
- Legal codes, i_ready=1: stream 4'b0001, 0010, 0100, 1000 back-to-back -> o_binary 0,1,2,3 one cycle later each, o_error=0, o_valid high continuously.
- Malformed: 4'b0000 then 4'b0110 -> o_binary=0, o_error=1 both; o_err_count=2.
- Backpressure: accept 4'b0100, hold i_ready=0 for 3 cycles while driving 4'b1000 -> o_binary=2 held, o_ready=0; release i_ready -> 4'b1000 accepted same cycle, o_binary=3 next cycle.
- Counter saturation: 260 accepted 4'b1111 words -> o_err_count=255, no wrap.
- Clear collision: i_clear_count=1 in the same cycle as accepted 4'b0011 with count=7 -> count=1; clear alone next cycle -> 0.
